// File: rtl/uart_tx_sequencer_if.sv
// Handshake bundle between the TX-FIFO/UART sequencer and its FIFO and transmitter.
// master = sequencer side, slave = FIFO/transmitter side.
interface uart_tx_sequencer_if #(
  parameter int B = 8
);
  logic         enable;
  logic         fifo_empty;
  logic [B-1:0] fifo_rd_data;
  logic         fifo_rd;
  logic         tx_start;
  logic [B-1:0] tx_data;
  logic         tx_done_tick;
  logic         err_clr;
  logic         busy;
  logic         err;
  logic [15:0]  frame_cnt;

  modport master (
    input  enable, fifo_empty, fifo_rd_data, tx_done_tick, err_clr,
    output fifo_rd, tx_start, tx_data, busy, err, frame_cnt
  );

  modport slave (
    output enable, fifo_empty, fifo_rd_data, tx_done_tick, err_clr,
    input  fifo_rd, tx_start, tx_data, busy, err, frame_cnt
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Pops words from a first-word-fall-through TX FIFO and launches one UART frame per word,
// with a per-frame completion timeout, a post-frame idle gap and a completed-frame counter.
module uart_tx_sequencer #(
  parameter int B       = 8,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  GAP_LAST  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_e       state_q;
  logic         armed_q;
  logic         fifo_rd_q;
  logic         tx_start_q;
  logic [B-1:0] tx_data_q;
  logic         err_q;
  logic [15:0]  frame_cnt_q;
  logic [15:0]  wait_cnt_q;
  logic [7:0]   gap_cnt_q;

  logic [15:0]  frame_cnt_d;
  logic [15:0]  wait_cnt_d;
  logic [7:0]   gap_cnt_d;

  assign frame_cnt_d = frame_cnt_q + 16'd1;
  assign wait_cnt_d  = wait_cnt_q + 16'd1;
  assign gap_cnt_d   = gap_cnt_q + 8'd1;

  // Sequencer FSM with registered strobes; armed_q holds off the first launch by one edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      fifo_rd_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
      wait_cnt_q  <= 16'd0;
      gap_cnt_q   <= 8'd0;
    end else begin
      armed_q    <= 1'b1;
      fifo_rd_q  <= 1'b0;
      tx_start_q <= 1'b0;
      // A timeout in the same cycle overrides this clear below.
      if (bus.err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (armed_q && bus.enable && !bus.fifo_empty) begin
            state_q   <= S_LOAD;
            fifo_rd_q <= 1'b1;
          end
        end
        S_LOAD: begin
          tx_data_q  <= bus.fifo_rd_data;
          tx_start_q <= 1'b1;
          state_q    <= S_START;
        end
        S_START: begin
          wait_cnt_q <= 16'd0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // Completion beats a coincident timeout.
          if (bus.tx_done_tick) begin
            frame_cnt_q <= frame_cnt_d;
            wait_cnt_q  <= 16'd0;
            gap_cnt_q   <= 8'd0;
            state_q     <= (GAP > 0) ? S_GAP : S_IDLE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            err_q      <= 1'b1;
            wait_cnt_q <= 16'd0;
            state_q    <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= 8'd0;
            state_q   <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_rd   = fifo_rd_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.err       = err_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 Parameter B, default 8: data width, matching the TX FIFO word width.
REQ-002 Parameter GAP, default 4: idle cycles inserted after each completed frame; 0 means no gap; range 0..255.
REQ-003 Parameter TIMEOUT, default 50000: maximum cycles spent in WAIT before abort; range 1..65535.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port enable, input, 1: when 1, new frames may be launched.
REQ-007 Port fifo_empty, input, 1: TX FIFO empty flag.
REQ-008 Port fifo_rd_data, input, B: TX FIFO head word; valid whenever fifo_empty=0 (first-word-fall-through).
REQ-009 Port fifo_rd, output, 1: one-cycle pop strobe to the TX FIFO.
REQ-010 Port tx_start, output, 1: one-cycle launch strobe to the UART transmitter.
REQ-011 Port tx_data, output, B: registered byte presented to the transmitter.
REQ-012 Port tx_done_tick, input, 1: one-cycle pulse from the transmitter at frame end.
REQ-013 Port err_clr, input, 1: synchronous clear of err.
REQ-014 Port busy, output, 1: 1 in every state except IDLE.
REQ-015 Port err, output, 1: sticky flag set on WAIT timeout.
REQ-016 Port frame_cnt, output, 16: count of completed frames.

Function
REQ-017 The FSM states SHALL be IDLE, LOAD, START, WAIT and GAP; all outputs are registered or Moore-decoded from state, with no combinational path from any input to any output.
REQ-018 IDLE -> LOAD when enable=1 and fifo_empty=0 at the clock edge; otherwise the FSM stays in IDLE.
REQ-019 LOAD is one cycle: fifo_rd=1, and tx_data is loaded from fifo_rd_data at the LOAD->START edge.
REQ-020 START is one cycle: tx_start=1, then START -> WAIT unconditionally.
REQ-021 WAIT -> GAP on tx_done_tick=1 (or -> IDLE when GAP=0), and frame_cnt increments by 1 modulo 2^16 on that edge.
REQ-022 tx_done_tick SHALL be ignored in every state other than WAIT.
REQ-023 A WAIT cycle counter SHALL clear on entry to WAIT; when it reaches TIMEOUT without tx_done_tick, the FSM goes to IDLE, err is set, and frame_cnt is not incremented.
REQ-024 When tx_done_tick and timeout coincide, tx_done_tick SHALL take priority: the frame counts as completed and err is unchanged.
REQ-025 GAP SHALL last exactly GAP cycles, then GAP -> IDLE.
REQ-026 Latency SHALL be fifo_empty falling (with enable=1) to fifo_rd = 1 cycle, and to tx_start = 2 cycles.
REQ-027 Back-to-back frames SHALL take a minimum of GAP+1 IDLE-inclusive cycles from the tx_done_tick edge to the next LOAD.
REQ-028 enable deasserted in LOAD, START, WAIT or GAP SHALL NOT abort the frame in flight; the frame completes and no new LOAD occurs.
REQ-029 fifo_rd SHALL be asserted at most once per frame and never while fifo_empty=1.
REQ-030 err_clr=1 SHALL clear err; if err_clr and a timeout occur in the same cycle, the timeout wins and err=1.
REQ-031 tx_data SHALL hold its value outside LOAD->START transitions.

Reset
REQ-032 While reset=0, asynchronously: state=IDLE, fifo_rd=0, tx_start=0, tx_data=0, busy=0, err=0, frame_cnt=0, and the WAIT and GAP counters are 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no further fifo_rd or tx_start; after release the FSM restarts from IDLE.
REQ-034 Release of reset SHALL be synchronous to clk, and the first LOAD occurs no earlier than the second rising edge after release.

Verification
REQ-035 Single frame: FIFO holds 0xAA, enable=1, transmitter returns tx_done_tick 10 cycles after tx_start -> fifo_rd one cycle after the edge, tx_start the next cycle with tx_data=0xAA, frame_cnt=1, busy low after GAP=4 cycles.
REQ-036 Burst: 16 words 0x00..0x0F queued -> 16 tx_start pulses in order with tx_data 0x00..0x0F, exactly 16 fifo_rd pulses, frame_cnt=16, no fifo_rd once fifo_empty=1.
REQ-037 Timeout: TIMEOUT=20, tx_done_tick withheld -> IDLE 20 cycles after entering WAIT, err=1, frame_cnt unchanged; err_clr pulse -> err=0.
REQ-038 Enable drop: enable falls during WAIT with 3 words queued -> the current frame completes, frame_cnt+1, and no further fifo_rd until enable=1.
REQ-039 Reset mid-frame: reset=0 during WAIT -> all outputs at reset values immediately, with no clock edge required; after release, the queued word is sent normally.
REQ-040 Coincidence and stray-tick checks: (a) tx_done_tick on the timeout cycle -> err=0 and frame_cnt+1; (b) tx_done_tick in IDLE or GAP -> no state or frame_cnt change.
